// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder-to-sequencer request bus and sequencer status outputs.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 6,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int SP_W = $clog2(DEPTH) + 1;
  logic             start;
  logic             stall;
  logic             halt_req;
  logic             jump_en;
  logic [PC_W-1:0]  jump_target;
  logic             branch_en;
  logic             branch_cond;
  logic [OFF_W-1:0] branch_off;
  logic             call_en;
  logic             ret_en;
  logic [PC_W-1:0]  PC;
  logic             halt;
  logic [SP_W-1:0]  sp;
  logic             stack_ovf;
  logic             stack_unf;
  logic [CNT_W-1:0] cycle_ct;
  logic [CNT_W-1:0] inst_ct;
  modport master (
    output start, stall, halt_req, jump_en, jump_target, branch_en, branch_cond,
           branch_off, call_en, ret_en,
    input  PC, halt, sp, stack_ovf, stack_unf, cycle_ct, inst_ct
  );
  modport slave (
    input  start, stall, halt_req, jump_en, jump_target, branch_en, branch_cond,
           branch_off, call_en, ret_en,
    output PC, halt, sp, stack_ovf, stack_unf, cycle_ct, inst_ct
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with jump, relative branch, call/return stack,
// stall, sticky halt and saturating cycle / retired-instruction counters.
module pc_sequencer #(
  parameter int PC_W       = 10,
  parameter int OFF_W      = 6,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16,
  parameter int START_ADDR = 0
) (
  input logic           CLK,
  input logic           reset_n,
  pc_sequencer_if.slave s
);
  localparam int SP_W = $clog2(DEPTH) + 1;
  localparam int IW   = $clog2(DEPTH);
  localparam logic [PC_W-1:0] START = PC_W'(START_ADDR);
  localparam logic [SP_W-1:0] FULL  = SP_W'(DEPTH);
  typedef enum logic {RUN, HALTED} state_t;
  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, pc_inc, pc_br, off_ext;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d;
  logic [PC_W-1:0]  stack_q [DEPTH];
  logic [PC_W-1:0]  stack_d [DEPTH];
  logic             push, retire, redirect;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction
  assign pc_inc  = pc_q + PC_W'(1);
  assign off_ext = PC_W'($signed(s.branch_off));
  assign pc_br   = pc_q + off_ext;
  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) state_q <= RUN;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (s.start) state_d = RUN;
    else if (state_q == RUN && s.halt_req) state_d = HALTED;
  end
  always_comb begin
    s.PC        = pc_q;
    s.halt      = state_q == HALTED;
    s.sp        = sp_q;
    s.stack_ovf = ovf_q;
    s.stack_unf = unf_q;
    s.cycle_ct  = cyc_q;
    s.inst_ct   = inst_q;
  end
  // halt_req outranks stall, so a stalled halt instruction still retires
  assign retire   = state_q == RUN && (s.halt_req || !s.stall);
  assign redirect = state_q == RUN && !s.halt_req && !s.stall;
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    cyc_d  = state_q == RUN ? sat_inc(cyc_q) : cyc_q;
    inst_d = retire ? sat_inc(inst_q) : inst_q;
    push   = 1'b0;
    if (s.start) begin
      pc_d   = START;
      sp_d   = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      cyc_d  = '0;
      inst_d = '0;
    end else if (redirect) begin
      if (s.ret_en) begin
        pc_d  = sp_q != '0 ? stack_q[IW'(sp_q - SP_W'(1))] : pc_inc;
        sp_d  = sp_q != '0 ? sp_q - SP_W'(1) : sp_q;
        unf_d = unf_q | (sp_q == '0);
      end else if (s.call_en) begin
        push  = sp_q != FULL;
        sp_d  = push ? sp_q + SP_W'(1) : sp_q;
        ovf_d = ovf_q | !push;
        pc_d  = s.jump_target;
      end else begin
        pc_d = s.jump_en ? s.jump_target : (s.branch_en && s.branch_cond) ? pc_br : pc_inc;
      end
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) stack_d[i] = stack_q[i];
    if (push) stack_d[IW'(sp_q)] = pc_inc;
  end
  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) begin
      pc_q   <= START;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      pc_q   <= pc_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
    end
  // return-stack contents are don't-care after reset, so no reset here
  always_ff @(posedge CLK)
    for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
endmodule
